// File: rtl/rf_seq_ctrl_if.sv
// Command handshake bundle for rf_seq_ctrl: one register-transfer command
// (op, destination, source, immediate) qualified by valid/ready.
interface rf_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src;
  logic [3:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: micro-sequencer for a 4x4-bit register file.
// Accepts one command at a time (LOAD, MOVE, ADD, SWAP) and steps the file's
// read/write controls through IDLE -> RD_A/RD_B -> WR_A/WR_B -> DONE.
// Optional feature macro: RF_SEQ_SWAP_EN. When undefined, op 11 (SWAP) is
// treated as illegal: it goes straight to DONE, sets err and touches nothing.
module rf_seq_ctrl (
  input  logic              fpga_clk,
  input  logic              rst_n,
  rf_seq_ctrl_if.slave      cmd,
  output logic [1:0]        rf_addr_x,
  output logic [1:0]        rf_addr_y,
  output logic              rf_rd_x,
  output logic              rf_rd_y,
  output logic              rf_wr_x,
  output logic [3:0]        rf_data_in,
  input  logic [3:0]        rf_data_out,
  output logic              done,
  output logic              carry,
  output logic              err,
  output logic [3:0]        sm_state,
  output logic [7:0]        op_count
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

`ifdef RF_SEQ_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD_A = 4'd1,
    RD_B = 4'd2,
    WR_A = 4'd3,
    WR_B = 4'd4,
    DONE = 4'd5
  } state_t;

  state_t     state;
  state_t     next_state;

  // started holds cmd_ready low through the first edge after reset release
  logic       started;
  logic       ready;
  logic       accept;
  logic       illegal;

  logic [1:0] op_q;
  logic [1:0] dst_q;
  logic [1:0] src_q;
  logic [3:0] imm_q;
  logic [3:0] temp_a;
  logic [3:0] temp_b;
  logic [4:0] sum;

  assign ready         = (state == IDLE) && started;
  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid && ready;
  assign illegal       = (cmd.cmd_op == OP_SWAP) && !SWAP_EN;
  assign sum           = {1'b0, temp_a} + {1'b0, temp_b};
  assign sm_state      = state;

  // State register; reset aborts any command in flight immediately
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state selection and Moore decode of the register-file controls
  always_comb begin
    next_state = IDLE;
    rf_addr_x  = 2'd0;
    rf_addr_y  = 2'd0;
    rf_rd_x    = 1'b0;
    rf_rd_y    = 1'b0;
    rf_wr_x    = 1'b0;
    rf_data_in = 4'd0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        next_state = IDLE;
        if (accept) begin
          case (cmd.cmd_op)
            OP_LOAD: next_state = WR_A;
            OP_MOVE: next_state = RD_B;
            OP_ADD:  next_state = RD_A;
            default: next_state = SWAP_EN ? RD_A : DONE;
          endcase
        end
      end
      RD_A: begin
        next_state = RD_B;
        rf_addr_x  = dst_q;
        rf_rd_x    = 1'b1;
      end
      RD_B: begin
        next_state = WR_A;
        rf_addr_y  = src_q;
        rf_rd_y    = 1'b1;
      end
      WR_A: begin
        next_state = (op_q == OP_SWAP) ? WR_B : DONE;
        rf_addr_x  = dst_q;
        rf_wr_x    = 1'b1;
        case (op_q)
          OP_LOAD: rf_data_in = imm_q;
          OP_ADD:  rf_data_in = sum[3:0];
          default: rf_data_in = temp_b;
        endcase
      end
      WR_B: begin
        next_state = DONE;
        rf_addr_x  = src_q;
        rf_wr_x    = 1'b1;
        rf_data_in = temp_a;
      end
      DONE: begin
        next_state = IDLE;
        done       = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command latch, read temps, carry/err flags and the completion counter
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      started  <= 1'b0;
      op_q     <= 2'd0;
      dst_q    <= 2'd0;
      src_q    <= 2'd0;
      imm_q    <= 4'd0;
      temp_a   <= 4'd0;
      temp_b   <= 4'd0;
      carry    <= 1'b0;
      err      <= 1'b0;
      op_count <= 8'd0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        op_q  <= cmd.cmd_op;
        dst_q <= cmd.cmd_dst;
        src_q <= cmd.cmd_src;
        imm_q <= cmd.cmd_imm;
        err   <= illegal;
      end
      if (state == RD_A) temp_a <= rf_data_out;
      if (state == RD_B) temp_b <= rf_data_out;
      if ((state == WR_A) && (op_q == OP_ADD)) carry <= sum[4];
      if (next_state == DONE) op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: scoreboard bench for rf_seq_ctrl. Directed commands push
// hand-computed write and completion expectations into queues; a monitor
// pops and compares whenever the DUT pulses rf_wr_x or done.
module tb_rf_seq_ctrl;

  logic       fpga_clk;
  logic       rst_n;
  logic [1:0] rf_addr_x;
  logic [1:0] rf_addr_y;
  logic       rf_rd_x;
  logic       rf_rd_y;
  logic       rf_wr_x;
  logic [3:0] rf_data_in;
  logic [3:0] rf_data_out;
  logic       done;
  logic       carry;
  logic       err;
  logic [3:0] sm_state;
  logic [7:0] op_count;

  rf_seq_ctrl_if ifc ();

  rf_seq_ctrl dut (
    .fpga_clk    (fpga_clk),
    .rst_n       (rst_n),
    .cmd         (ifc),
    .rf_addr_x   (rf_addr_x),
    .rf_addr_y   (rf_addr_y),
    .rf_rd_x     (rf_rd_x),
    .rf_rd_y     (rf_rd_y),
    .rf_wr_x     (rf_wr_x),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out),
    .done        (done),
    .carry       (carry),
    .err         (err),
    .sm_state    (sm_state),
    .op_count    (op_count)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // Register file model attached to the controller
  logic [3:0] mem [4];
  always @(posedge fpga_clk) if (rf_wr_x) mem[rf_addr_x] <= rf_data_in;
  assign rf_data_out = rf_rd_x ? mem[rf_addr_x] : (rf_rd_y ? mem[rf_addr_y] : 4'd0);

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int lat; int cry; int er; int cnt; } done_t;

  wr_t   wq[$];
  done_t dq[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  task automatic expectWrite(input int a, input int d, input int c);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = c;
    wq.push_back(w);
  endtask

  task automatic expectDone(input int lat, input int cry, input int er, input int cnt);
    done_t e;
    e.lat = lat; e.cry = cry; e.er = er; e.cnt = cnt;
    dq.push_back(e);
  endtask

  // Wait (bounded) for an IDLE controller, present one command, hold it over the accept edge
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] dst,
                               input logic [1:0] src, input logic [3:0] imm);
    @(negedge fpga_clk);
    for (int i = 0; i < 50 && !ifc.cmd_ready; i++) @(negedge fpga_clk);
    if (!ifc.cmd_ready) reportFail("ready_timeout", "cmd_ready never rose");
    ifc.cmd_op    = op;
    ifc.cmd_dst   = dst;
    ifc.cmd_src   = src;
    ifc.cmd_imm   = imm;
    ifc.cmd_valid = 1'b1;
    @(posedge fpga_clk);
    #1 ifc.cmd_valid = 1'b0;
  endtask

  // Flag the accept edge as seen just before the state register updates
  bit acc_edge = 0;
  always @(posedge fpga_clk) acc_edge = ifc.cmd_valid && ifc.cmd_ready && rst_n;

  // Monitor: counts cycles since acceptance and scores writes and completions
  bit    busy = 0;
  int    cyc = 0;
  wr_t   mw;
  done_t md;
  always @(negedge fpga_clk) begin
    if (!rst_n) begin
      busy = 0;
      cyc  = 0;
    end else begin
      if (acc_edge) begin
        busy = 1;
        cyc  = 1;
      end else if (busy) begin
        cyc++;
      end
      if (rf_wr_x) begin
        if (wq.size() == 0) reportFail("unexpected_write", $sformatf("addr %0d data %0d", rf_addr_x, rf_data_in));
        else begin
          mw = wq.pop_front();
          checkOutput("wr_addr", rf_addr_x, mw.addr);
          checkOutput("wr_data", rf_data_in, mw.data);
          checkOutput("wr_cycle", cyc, mw.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) reportFail("unexpected_done", $sformatf("op_count %0d", op_count));
        else begin
          md = dq.pop_front();
          checkOutput("done_latency", cyc, md.lat);
          checkOutput("done_carry", carry, md.cry);
          checkOutput("done_err", err, md.er);
          checkOutput("done_op_count", op_count, md.cnt);
        end
        busy = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'd0;
    ifc.cmd_dst   = 2'd0;
    ifc.cmd_src   = 2'd0;
    ifc.cmd_imm   = 4'd0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", ifc.cmd_ready, 0);
    checkOutput("rst_state", sm_state, 0);
    checkOutput("rst_wr_x", rf_wr_x, 0);
    checkOutput("rst_op_count", op_count, 0);
    checkOutput("rst_flags", {done, carry, err}, 0);
    repeat (2) @(negedge fpga_clk);
    rst_n = 1'b1;
    #1 checkOutput("release_ready_low", ifc.cmd_ready, 0);
    @(negedge fpga_clk);
    checkOutput("release_ready_high", ifc.cmd_ready, 1);

    $display("[TB] LOAD r2=9");
    expectWrite(2, 9, 1); expectDone(2, 0, 0, 1);
    applyStimulus(2'b00, 2'd2, 2'd0, 4'd9);

    $display("[TB] LOAD r0=7, r3=12, MOVE r3->r0");
    expectWrite(0, 7, 1);  expectDone(2, 0, 0, 2);
    applyStimulus(2'b00, 2'd0, 2'd0, 4'd7);
    expectWrite(3, 12, 1); expectDone(2, 0, 0, 3);
    applyStimulus(2'b00, 2'd3, 2'd0, 4'd12);
    expectWrite(0, 12, 2); expectDone(3, 0, 0, 4);
    applyStimulus(2'b01, 2'd0, 2'd3, 4'd0);
    @(negedge fpga_clk);
    checkOutput("move_state1", sm_state, 2);
    checkOutput("move_rd_y", rf_rd_y, 1);
    checkOutput("move_rd_x", rf_rd_x, 0);
    checkOutput("move_addr_y", rf_addr_y, 3);
    @(negedge fpga_clk); checkOutput("move_state2", sm_state, 3);
    @(negedge fpga_clk); checkOutput("move_state3", sm_state, 5);
    @(negedge fpga_clk); checkOutput("move_state4", sm_state, 0);

    $display("[TB] ADD 9+10 and 3+1");
    expectWrite(1, 9, 1);  expectDone(2, 0, 0, 5);
    applyStimulus(2'b00, 2'd1, 2'd0, 4'd9);
    expectWrite(2, 10, 1); expectDone(2, 0, 0, 6);
    applyStimulus(2'b00, 2'd2, 2'd0, 4'd10);
    expectWrite(1, 3, 3);  expectDone(4, 1, 0, 7);
    applyStimulus(2'b10, 2'd1, 2'd2, 4'd0);
    expectWrite(2, 1, 1);  expectDone(2, 1, 0, 8);
    applyStimulus(2'b00, 2'd2, 2'd0, 4'd1);
    expectWrite(1, 4, 3);  expectDone(4, 0, 0, 9);
    applyStimulus(2'b10, 2'd1, 2'd2, 4'd0);

    $display("[TB] SWAP r0=5, r3=11");
    expectWrite(0, 5, 1);  expectDone(2, 0, 0, 10);
    applyStimulus(2'b00, 2'd0, 2'd0, 4'd5);
    expectWrite(3, 11, 1); expectDone(2, 0, 0, 11);
    applyStimulus(2'b00, 2'd3, 2'd0, 4'd11);
`ifdef RF_SEQ_SWAP_EN
    expectWrite(0, 11, 3); expectWrite(3, 5, 4); expectDone(5, 0, 0, 12);
`else
    expectDone(1, 0, 1, 12);
`endif
    applyStimulus(2'b11, 2'd0, 2'd3, 4'd0);

    $display("[TB] busy ADD with cmd_valid held");
    expectWrite(1, 6, 1);  expectDone(2, 0, 0, 13);
    applyStimulus(2'b00, 2'd1, 2'd0, 4'd6);
    expectWrite(1, 12, 3); expectDone(4, 0, 0, 14);
    applyStimulus(2'b10, 2'd1, 2'd1, 4'd0);
    ifc.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ifc.cmd_op  = 2'(i);
      ifc.cmd_dst = 2'(i + 1);
      ifc.cmd_src = 2'(i + 2);
      ifc.cmd_imm = 4'(15 - i);
      @(negedge fpga_clk);
      if (ifc.cmd_ready) break;
    end
    checkOutput("busy_ready_at_idle", ifc.cmd_ready, 1);
    checkOutput("busy_state_idle", sm_state, 0);
    expectWrite(2, 5, 1); expectDone(2, 0, 0, 15);
    ifc.cmd_op  = 2'b00;
    ifc.cmd_dst = 2'd2;
    ifc.cmd_src = 2'd0;
    ifc.cmd_imm = 4'd5;
    @(posedge fpga_clk);
    #1 ifc.cmd_valid = 1'b0;

    $display("[TB] reset during WR_A");
`ifdef RF_SEQ_SWAP_EN
    expectWrite(0, 5, 3);
    applyStimulus(2'b11, 2'd0, 2'd3, 4'd0);
`else
    expectWrite(0, 0, 3);
    applyStimulus(2'b10, 2'd0, 2'd3, 4'd0);
`endif
    repeat (3) @(negedge fpga_clk);
    checkOutput("pre_reset_state", sm_state, 3);
    checkOutput("pre_reset_wr_x", rf_wr_x, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_wr_x", rf_wr_x, 0);
    checkOutput("mid_reset_state", sm_state, 0);
    checkOutput("mid_reset_data", rf_data_in, 0);
    checkOutput("mid_reset_op_count", op_count, 0);
    repeat (2) @(negedge fpga_clk);
`ifdef RF_SEQ_SWAP_EN
    checkOutput("abort_src_kept", mem[3], 5);
    checkOutput("abort_dst_kept", mem[0], 11);
`else
    checkOutput("abort_src_kept", mem[3], 11);
    checkOutput("abort_dst_kept", mem[0], 5);
`endif
    rst_n = 1'b1;
    #1 checkOutput("rerelease_ready_low", ifc.cmd_ready, 0);
    @(negedge fpga_clk);
    checkOutput("rerelease_ready_high", ifc.cmd_ready, 1);
    checkOutput("rerelease_op_count", op_count, 0);

    $display("[TB] LOAD after reset");
    expectWrite(1, 13, 1); expectDone(2, 0, 0, 1);
    applyStimulus(2'b00, 2'd1, 2'd0, 4'd13);
    for (int i = 0; i < 20 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge fpga_clk);
    @(negedge fpga_clk);
    checkOutput("leftover_writes", wq.size(), 0);
    checkOutput("leftover_dones", dq.size(), 0);
    checkOutput("final_mem1", mem[1], 13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
